// File: rtl/otter_imm_pkg.sv
// Shared types, opcode constants and the immediate selection function for the
// Otter immediate-generation stage.
package otter_imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;

  // Result is always computed at the widest XLEN; callers keep the low XLEN bits.
  typedef struct packed {
    logic [63:0] imm;
    imm_type_e   typ;
    logic        illegal;
  } imm_sel_t;

  function automatic imm_sel_t imm_select(input logic [31:0] ir, input logic xlen64);
    imm_sel_t   r;
    logic [2:0] funct3;
    logic       is_shift;
    funct3   = ir[14:12];
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    r.imm     = '0;
    r.typ     = IMM_NONE;
    r.illegal = 1'b0;
    unique case (ir[6:0])
      OPC_LOAD, OPC_JALR: begin
        r.typ = IMM_I;
        r.imm = {{52{ir[31]}}, ir[31:20]};
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          r.typ = IMM_SHAMT;
          // funct7 (including ir[25] on RV32) never leaks into the shift amount.
          r.imm = xlen64 ? {58'd0, ir[25:20]} : {59'd0, ir[24:20]};
        end else begin
          r.typ = IMM_I;
          r.imm = {{52{ir[31]}}, ir[31:20]};
        end
      end
      OPC_OP_IMM32: begin
        if (!xlen64) begin
          r.illegal = 1'b1;
        end else if (is_shift) begin
          r.typ = IMM_SHAMT;
          r.imm = {59'd0, ir[24:20]};
        end else begin
          r.typ = IMM_I;
          r.imm = {{52{ir[31]}}, ir[31:20]};
        end
      end
      OPC_STORE: begin
        r.typ = IMM_S;
        r.imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OPC_BRANCH: begin
        r.typ = IMM_B;
        r.imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        r.typ = IMM_U;
        r.imm = {{32{ir[31]}}, ir[31:12], 12'd0};
      end
      OPC_JAL: begin
        r.typ = IMM_J;
        r.imm = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      OPC_OP: r.typ = IMM_NONE;
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Decode-side and execute-side handshakes of the immediate-generation stage.
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  import otter_imm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_ir;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_type_e       out_type;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  // Upstream decode plus downstream consumer, seen from outside the stage.
  modport master (
    output in_valid, in_ir, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_pc, out_illegal
  );

  // The stage itself.
  modport slave (
    input  in_valid, in_ir, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_pc, out_illegal
  );
endinterface

// File: rtl/imm_skid_fifo.sv
// Two-entry valid/ready buffer; in_ready depends only on occupancy, so no
// combinational path runs from the consumer's ready back to the producer.
module imm_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  // flush wins over any transfer offered in the same cycle
  assign push       = push_valid && push_ready && !flush;
  assign pop        = pop_valid && pop_ready && !flush;
  assign pop_data   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: storage is reset on purpose: the head entry drives the outputs, which must read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: classifies the instruction word,
// selects one sign-extended immediate and queues it with its tag and pc.
module imm_gen_stage
  import otter_imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit PASS_PC = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  imm_gen_stage_if.slave bus
);

  localparam int ENTRY_W = 2 * XLEN + 4;

  imm_sel_t             sel;
  logic [XLEN-1:0]      imm_x;
  logic [XLEN-1:0]      pc_x;
  logic [ENTRY_W-1:0]   push_data;
  logic [ENTRY_W-1:0]   head;

  // Classify the incoming instruction word.
  always_comb begin
    sel = imm_select(bus.in_ir, XLEN == 64);
  end

  if (XLEN == 64) begin : g_full
    assign imm_x = sel.imm;
  end else begin : g_trunc
    logic unused_hi;
    assign imm_x     = sel.imm[XLEN-1:0];
    assign unused_hi = ^sel.imm[63:XLEN];
  end

  if (PASS_PC) begin : g_pc
    assign pc_x = bus.in_pc;
  end else begin : g_no_pc
    logic unused_pc;
    assign pc_x      = '0;
    assign unused_pc = ^bus.in_pc;
  end

  // Entry layout, MSB first: imm, type, illegal, pc.
  assign push_data = {imm_x, sel.typ, sel.illegal, pc_x};

  imm_skid_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (bus.in_valid),
    .push_ready (bus.in_ready),
    .push_data  (push_data),
    .pop_valid  (bus.out_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (head)
  );

  assign bus.out_imm     = head[ENTRY_W-1 -: XLEN];
  assign bus.out_type    = imm_type_e'(head[XLEN+3 -: 3]);
  assign bus.out_illegal = head[XLEN];
  assign bus.out_pc      = head[XLEN-1:0];

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an RV32 and an RV64 instance receive identical
// stimulus; a vector table, directed sequences and a random scoreboard run.
module tb_imm_gen_stage;
  import otter_imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32)) bus32 ();
  imm_gen_stage_if #(.XLEN(64)) bus64 ();

  imm_gen_stage #(.XLEN(32), .PASS_PC(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32)
  );
  imm_gen_stage #(.XLEN(64), .PASS_PC(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64)
  );

  typedef struct {
    logic [63:0] imm;
    imm_type_e   t;
    logic        ill;
    logic [63:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] imm32;
    imm_type_e   t32;
    logic        ill32;
    logic [63:0] imm64;
    imm_type_e   t64;
    logic        ill64;
  } vec_t;

  exp_t q32[$];
  exp_t q64[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference immediates from field arithmetic on the instruction value.
  function automatic exp_t ref_model(input logic [31:0] ir, input int xlen, input logic [63:0] pc);
    exp_t e;
    longint unsigned u;
    longint i_imm, s_imm, b_imm, u_imm, j_imm, v;
    int opc, f3;
    u     = 64'(ir);
    opc   = int'(u & 127);
    f3    = int'((u >> 12) & 7);
    i_imm = longint'(u >> 20);
    if (i_imm >= 2048) i_imm -= 4096;
    s_imm = longint'(((u >> 25) << 5) | ((u >> 7) & 31));
    if (s_imm >= 2048) s_imm -= 4096;
    b_imm = longint'((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                     (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1));
    if (b_imm >= 4096) b_imm -= 8192;
    u_imm = longint'((u >> 12) << 12);
    if (u_imm >= (longint'(1) << 31)) u_imm -= (longint'(1) << 32);
    j_imm = longint'((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                     (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1));
    if (j_imm >= (longint'(1) << 20)) j_imm -= (longint'(1) << 21);
    v = 0;
    e.t = IMM_NONE;
    e.ill = 1'b0;
    if (opc == 3 || opc == 103) begin
      e.t = IMM_I; v = i_imm;
    end else if (opc == 19) begin
      if (f3 == 1 || f3 == 5) begin
        e.t = IMM_SHAMT; v = longint'((u >> 20) & ((xlen == 64) ? 63 : 31));
      end else begin
        e.t = IMM_I; v = i_imm;
      end
    end else if (opc == 27) begin
      if (xlen != 64) e.ill = 1'b1;
      else if (f3 == 1 || f3 == 5) begin
        e.t = IMM_SHAMT; v = longint'((u >> 20) & 31);
      end else begin
        e.t = IMM_I; v = i_imm;
      end
    end else if (opc == 35) begin
      e.t = IMM_S; v = s_imm;
    end else if (opc == 99) begin
      e.t = IMM_B; v = b_imm;
    end else if (opc == 55 || opc == 23) begin
      e.t = IMM_U; v = u_imm;
    end else if (opc == 111) begin
      e.t = IMM_J; v = j_imm;
    end else if (opc != 51) begin
      e.ill = 1'b1;
    end
    e.imm = v;
    e.pc  = pc;
    if (xlen == 32) begin
      e.imm = e.imm & 64'h0000_0000_FFFF_FFFF;
      e.pc  = e.pc & 64'h0000_0000_FFFF_FFFF;
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ir, input logic [63:0] pc, input logic rdy);
    bus32.in_valid  = v;
    bus32.in_ir     = ir;
    bus32.in_pc     = pc[31:0];
    bus32.out_ready = rdy;
    bus64.in_valid  = v;
    bus64.in_ir     = ir;
    bus64.in_pc     = pc;
    bus64.out_ready = rdy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid32"}, 64'(bus32.out_valid), 64'd0);
    check({tag, "_valid64"}, 64'(bus64.out_valid), 64'd0);
    check({tag, "_ready32"}, 64'(bus32.in_ready), 64'd1);
    check({tag, "_ready64"}, 64'(bus64.in_ready), 64'd1);
  endtask

  task automatic check_head(input string tag, input logic [31:0] imm32, input logic [63:0] imm64,
                            input imm_type_e t);
    check({tag, "_valid32"}, 64'(bus32.out_valid), 64'd1);
    check({tag, "_imm32"}, 64'(bus32.out_imm), 64'(imm32));
    check({tag, "_type32"}, 64'(bus32.out_type), 64'(t));
    check({tag, "_imm64"}, bus64.out_imm, imm64);
  endtask

  // One cycle of the scoreboard for one instance (w=0: RV32, w=1: RV64).
  task automatic sb_step(input int w, input logic iv, input logic [31:0] ir, input logic [63:0] pc,
                         input logic rdy, input logic fl, input logic d_in_ready,
                         input logic d_out_valid, input logic [63:0] d_imm, input logic [2:0] d_type,
                         input logic d_ill, input logic [63:0] d_pc);
    int   sz;
    exp_t h;
    string nm;
    nm = (w == 0) ? "rnd32" : "rnd64";
    sz = (w == 0) ? q32.size() : q64.size();
    check({nm, "_in_ready"}, 64'(d_in_ready), 64'(sz < 2));
    check({nm, "_out_valid"}, 64'(d_out_valid), 64'(sz != 0));
    if (sz != 0) begin
      h = (w == 0) ? q32[0] : q64[0];
      check({nm, "_imm"}, d_imm, h.imm);
      check({nm, "_type"}, 64'(d_type), 64'(h.t));
      check({nm, "_ill"}, 64'(d_ill), 64'(h.ill));
      check({nm, "_pc"}, d_pc, h.pc);
    end
    if (fl) begin
      if (w == 0) q32.delete(); else q64.delete();
    end else begin
      if (sz != 0 && rdy) begin
        if (w == 0) void'(q32.pop_front()); else void'(q64.pop_front());
      end
      if (iv && sz < 2) begin
        if (w == 0) q32.push_back(ref_model(ir, 32, pc));
        else q64.push_back(ref_model(ir, 64, pc));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] pc;
    logic [31:0] r;
    logic [31:0] ir;
    logic [6:0]  pool [12];
    logic [31:0] drain_exp [3];
    int          got;
    logic        acc;
    logic        iv, rdy, fl;

    drive(1'b0, 32'd0, 64'd0, 1'b1);
    #12;
    check("rst_valid32", 64'(bus32.out_valid), 64'd0);
    check("rst_ready32", 64'(bus32.in_ready), 64'd1);
    check("rst_imm32", 64'(bus32.out_imm), 64'd0);
    check("rst_type32", 64'(bus32.out_type), 64'(IMM_NONE));
    check("rst_pc32", 64'(bus32.out_pc), 64'd0);
    check("rst_ill32", 64'(bus32.out_illegal), 64'd0);
    check("rst_valid64", 64'(bus64.out_valid), 64'd0);
    check("rst_imm64", bus64.out_imm, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // ---- vector table: single instruction, out_ready held high ----
    tbl.push_back('{32'hFFF00093, 32'hFFFFFFFF, IMM_I, 1'b0, 64'hFFFFFFFF_FFFFFFFF, IMM_I, 1'b0});
    tbl.push_back('{32'hFE112E23, 32'hFFFFFFFC, IMM_S, 1'b0, 64'hFFFFFFFF_FFFFFFFC, IMM_S, 1'b0});
    tbl.push_back('{32'hFF9FF06F, 32'hFFFFFFF8, IMM_J, 1'b0, 64'hFFFFFFFF_FFFFFFF8, IMM_J, 1'b0});
    tbl.push_back('{32'h4030D093, 32'h00000003, IMM_SHAMT, 1'b0, 64'h3, IMM_SHAMT, 1'b0});
    tbl.push_back('{32'h123452B7, 32'h12345000, IMM_U, 1'b0, 64'h12345000, IMM_U, 1'b0});
    tbl.push_back('{32'h800002B7, 32'h80000000, IMM_U, 1'b0, 64'hFFFFFFFF_80000000, IMM_U, 1'b0});
    tbl.push_back('{32'h0000000B, 32'h0, IMM_NONE, 1'b1, 64'h0, IMM_NONE, 1'b1});
    tbl.push_back('{32'h002081B3, 32'h0, IMM_NONE, 1'b0, 64'h0, IMM_NONE, 1'b0});
    tbl.push_back('{32'hFE000EE3, 32'hFFFFFFFC, IMM_B, 1'b0, 64'hFFFFFFFF_FFFFFFFC, IMM_B, 1'b0});
    tbl.push_back('{32'h00001017, 32'h00001000, IMM_U, 1'b0, 64'h1000, IMM_U, 1'b0});
    tbl.push_back('{32'h0010009B, 32'h0, IMM_NONE, 1'b1, 64'h1, IMM_I, 1'b0});
    tbl.push_back('{32'h4030D09B, 32'h0, IMM_NONE, 1'b1, 64'h3, IMM_SHAMT, 1'b0});
    tbl.push_back('{32'h4200D09B, 32'h0, IMM_NONE, 1'b1, 64'h0, IMM_SHAMT, 1'b0});
    tbl.push_back('{32'h01F09093, 32'h0000001F, IMM_SHAMT, 1'b0, 64'h1F, IMM_SHAMT, 1'b0});
    tbl.push_back('{32'h02009093, 32'h00000000, IMM_SHAMT, 1'b0, 64'h20, IMM_SHAMT, 1'b0});
    tbl.push_back('{32'h00008067, 32'h0, IMM_I, 1'b0, 64'h0, IMM_I, 1'b0});
    tbl.push_back('{32'h7FF02083, 32'h000007FF, IMM_I, 1'b0, 64'h7FF, IMM_I, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      pc = 64'h8000_0000_0000_1000 + 64'(i * 4);
      drive(1'b1, tbl[i].ir, pc, 1'b1);
      cyc();
      drive(1'b0, 32'd0, 64'd0, 1'b1);
      check($sformatf("tbl%0d_valid32", i), 64'(bus32.out_valid), 64'd1);
      check($sformatf("tbl%0d_imm32", i), 64'(bus32.out_imm), 64'(tbl[i].imm32));
      check($sformatf("tbl%0d_type32", i), 64'(bus32.out_type), 64'(tbl[i].t32));
      check($sformatf("tbl%0d_ill32", i), 64'(bus32.out_illegal), 64'(tbl[i].ill32));
      check($sformatf("tbl%0d_pc32", i), 64'(bus32.out_pc), 64'(pc[31:0]));
      check($sformatf("tbl%0d_valid64", i), 64'(bus64.out_valid), 64'd1);
      check($sformatf("tbl%0d_imm64", i), bus64.out_imm, tbl[i].imm64);
      check($sformatf("tbl%0d_type64", i), 64'(bus64.out_type), 64'(tbl[i].t64));
      check($sformatf("tbl%0d_ill64", i), 64'(bus64.out_illegal), 64'(tbl[i].ill64));
      check($sformatf("tbl%0d_pc64", i), bus64.out_pc, pc);
    end
    cyc();
    check_idle("tbl_end");

    // ---- back-to-back: one result per cycle ----
    drive(1'b1, 32'hFE112E23, 64'd0, 1'b1);
    cyc();
    drive(1'b1, 32'hFF9FF06F, 64'd0, 1'b1);
    check_head("b2b_sw", 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, IMM_S);
    cyc();
    drive(1'b0, 32'd0, 64'd0, 1'b1);
    check_head("b2b_jal", 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, IMM_J);
    cyc();
    check_idle("b2b_end");

    // ---- stall: fill, hold off third, then drain in order ----
    drain_exp[0] = 32'hFFFFFFFF;
    drain_exp[1] = 32'h12345000;
    drain_exp[2] = 32'h00000003;
    drive(1'b1, 32'hFFF00093, 64'd0, 1'b0);
    cyc();
    drive(1'b1, 32'h123452B7, 64'd0, 1'b0);
    check("stall_ready_after1", 64'(bus32.in_ready), 64'd1);
    cyc();
    drive(1'b1, 32'h4030D093, 64'd0, 1'b0);
    check("stall_full32", 64'(bus32.in_ready), 64'd0);
    check("stall_full64", 64'(bus64.in_ready), 64'd0);
    cyc();
    cyc();
    check("stall_hold_ready", 64'(bus32.in_ready), 64'd0);
    check_head("stall_hold", 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, IMM_I);
    bus32.out_ready = 1'b1;
    bus64.out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus32.out_valid) begin
        if (got < 3) check($sformatf("drain%0d_imm", got), 64'(bus32.out_imm), 64'(drain_exp[got]));
        else check("drain_extra", 64'(got), 64'd3);
        got++;
      end
      acc = bus32.in_valid && bus32.in_ready;
      cyc();
      if (acc) drive(1'b0, 32'd0, 64'd0, 1'b1);
    end
    check("drain_count", 64'(got), 64'd3);
    check_idle("drain_end");

    // ---- flush with two entries and an offered input ----
    drive(1'b1, 32'hFFF00093, 64'd0, 1'b0);
    cyc();
    cyc();
    drive(1'b1, 32'h123452B7, 64'd0, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'd0, 64'd0, 1'b1);
    check_idle("flush_full");
    cyc();
    check_idle("flush_full_after");

    // ---- flush with one entry: simultaneous push and pop discarded ----
    drive(1'b1, 32'hFFF00093, 64'd0, 1'b1);
    cyc();
    drive(1'b1, 32'h123452B7, 64'd0, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'd0, 64'd0, 1'b1);
    check_idle("flush_one");
    cyc();
    check_idle("flush_one_after");
    drive(1'b1, 32'h0000000B, 64'd0, 1'b1);
    cyc();
    drive(1'b0, 32'd0, 64'd0, 1'b1);
    check_head("post_flush_illegal", 32'h0, 64'h0, IMM_NONE);
    check("post_flush_ill32", 64'(bus32.out_illegal), 64'd1);
    check("post_flush_ill64", 64'(bus64.out_illegal), 64'd1);
    cyc();

    // ---- asynchronous reset mid-burst ----
    drive(1'b1, 32'h800002B7, 64'd0, 1'b0);
    cyc();
    check_head("pre_rst", 32'h80000000, 64'hFFFFFFFF_80000000, IMM_U);
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_imm64", bus64.out_imm, 64'd0);
    check("async_rst_type32", 64'(bus32.out_type), 64'(IMM_NONE));
    drive(1'b0, 32'd0, 64'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // ---- randomized traffic against the reference model ----
    pool = '{OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_STORE, OPC_BRANCH, OPC_LUI,
             OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, 7'h0B, 7'h7F};
    q32.delete();
    q64.delete();
    for (int n = 0; n < 600; n++) begin
      r   = $urandom();
      ir  = {r[31:7], pool[$urandom_range(0, 11)]};
      pc  = {$urandom(), $urandom()};
      iv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      drive(iv, ir, pc, rdy);
      flush = fl;
      @(negedge clk);
      sb_step(0, iv, ir, pc, rdy, fl, bus32.in_ready, bus32.out_valid, 64'(bus32.out_imm),
              bus32.out_type, bus32.out_illegal, 64'(bus32.out_pc));
      sb_step(1, iv, ir, pc, rdy, fl, bus64.in_ready, bus64.out_valid, bus64.out_imm,
              bus64.out_type, bus64.out_illegal, bus64.out_pc);
      cyc();
    end
    flush = 1'b0;
    drive(1'b0, 32'd0, 64'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
